// File: rtl/banked_main_mem.sv
// Banked main-memory model: one bank per word of a block, fixed request-to-response
// latency, single-word accesses with byte strobes and whole-block refills/write-backs.
module banked_main_mem #(
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_W          = 32,
    parameter int DEPTH_BLOCKS    = 1024,
    parameter int LATENCY         = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic                              req_block,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_wdata,
    input  logic [DATA_W/8-1:0]               req_wstrb,
    input  logic [WORDS_PER_BLOCK*DATA_W-1:0] req_block_wdata,
    output logic                              resp_valid,
    output logic [DATA_W-1:0]                 resp_rdata,
    output logic [WORDS_PER_BLOCK*DATA_W-1:0] resp_block_rdata,
    output logic                              busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int BOFF   = $clog2(STRB_W);
    localparam int WIDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int BIDX_W = $clog2(DEPTH_BLOCKS);
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int BLK_W  = WORDS_PER_BLOCK * DATA_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               accept, commit;

    logic               write_reg, block_reg;
    logic [WIDX_W-1:0]  widx_reg;
    logic [BIDX_W-1:0]  bidx_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [STRB_W-1:0]  wstrb_reg;
    logic [BLK_W-1:0]   bwdata_reg;

    logic [WIDX_W-1:0]  req_widx;
    logic [BIDX_W-1:0]  req_bidx;
    logic [BIDX_W-1:0]  rd_bidx;
    logic [BLK_W-1:0]   merged_blk;
    logic               unused_addr;

    // Offset bits and bits above the memory size are don't-care (addresses alias).
    assign unused_addr = ^req_addr;
    assign req_widx    = req_addr[BOFF +: WIDX_W];
    assign req_bidx    = req_addr[BOFF + WIDX_W +: BIDX_W];

    assign req_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign resp_valid = (state_reg == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        if (clr) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        accept     = 1'b1;
                        state_next = WAIT;
                        count_next = CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (count_reg == CNT_W'(LATENCY)) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_next = IDLE;
                    count_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_reg  <= 1'b0;
            block_reg  <= 1'b0;
            widx_reg   <= '0;
            bidx_reg   <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            bwdata_reg <= '0;
        end else if (accept) begin
            write_reg  <= req_write;
            block_reg  <= req_block;
            widx_reg   <= req_widx;
            bidx_reg   <= req_bidx;
            wdata_reg  <= req_wdata;
            wstrb_reg  <= req_wstrb;
            bwdata_reg <= req_block_wdata;
        end
    end

    // Read from the incoming address while idle so the bank outputs are valid
    // by the commit edge even when LATENCY is 1.
    assign rd_bidx = (state_reg == IDLE) ? req_bidx : bidx_reg;

    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH_BLOCKS];
        logic [DATA_W-1:0] rd_reg;
        logic [DATA_W-1:0] merged;
        logic              hit;

        assign hit = block_reg || (widx_reg == WIDX_W'(gi));

        always_comb begin
            merged = rd_reg;
            if (write_reg && block_reg) begin
                merged = bwdata_reg[gi*DATA_W +: DATA_W];
            end else if (write_reg && hit) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_reg[b]) begin
                        merged[b*8 +: 8] = wdata_reg[b*8 +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (commit && write_reg && hit) begin
                mem[bidx_reg] <= merged;
            end
            rd_reg <= mem[rd_bidx];
        end

        assign merged_blk[gi*DATA_W +: DATA_W] = merged;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata       <= '0;
            resp_block_rdata <= '0;
        end else if (commit) begin
            resp_rdata       <= merged_blk[widx_reg*DATA_W +: DATA_W];
            resp_block_rdata <= merged_blk;
        end
    end

endmodule

// File: tb/tb_banked_main_mem.sv
// Randomised bench for banked_main_mem: a default instance and a small
// 8-word/latency-1/16-block instance, both checked against a flat word-array model.
module tb_banked_main_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0, req_write = 1'b0, req_block = 1'b0;
    logic [31:0]  req_addr = '0, req_wdata = '0;
    logic [3:0]   req_wstrb = '0;
    logic [255:0] req_bw = '0;
    bit           cur = 1'b0;

    logic         a_valid, a_ready, a_rvalid, a_busy;
    logic [31:0]  a_rdata;
    logic [127:0] a_brdata;
    logic         b_valid, b_ready, b_rvalid, b_busy;
    logic [31:0]  b_rdata;
    logic [255:0] b_brdata;

    assign a_valid = req_valid && !cur;
    assign b_valid = req_valid && cur;

    banked_main_mem #(.DATA_W(32), .WORDS_PER_BLOCK(4), .ADDR_W(32),
                      .DEPTH_BLOCKS(1024), .LATENCY(3)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
        .req_block(req_block), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_block_wdata(req_bw[127:0]),
        .resp_valid(a_rvalid), .resp_rdata(a_rdata),
        .resp_block_rdata(a_brdata), .busy(a_busy)
    );

    banked_main_mem #(.DATA_W(32), .WORDS_PER_BLOCK(8), .ADDR_W(32),
                      .DEPTH_BLOCKS(16), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
        .req_block(req_block), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_block_wdata(req_bw),
        .resp_valid(b_rvalid), .resp_rdata(b_rdata),
        .resp_block_rdata(b_brdata), .busy(b_busy)
    );

    logic         o_ready, o_rvalid, o_busy;
    logic [31:0]  o_rdata;
    logic [255:0] o_block;
    always_comb begin
        o_ready  = cur ? b_ready  : a_ready;
        o_rvalid = cur ? b_rvalid : a_rvalid;
        o_busy   = cur ? b_busy   : a_busy;
        o_rdata  = cur ? b_rdata  : a_rdata;
        o_block  = cur ? b_brdata : {128'b0, a_brdata};
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] model [2][4096];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction on the currently selected instance.
    task automatic op(input bit w, input bit bk, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [255:0] bw);
        int wpb, nw, lat, idx, base, n;
        logic [255:0] exp_blk;
        logic [31:0]  exp_word;
        wpb  = cur ? 8 : 4;
        nw   = cur ? 128 : 4096;
        lat  = cur ? 1 : 3;
        idx  = int'(addr >> 2) % nw;
        base = idx - (idx % wpb);
        if (w && bk) begin
            for (int k = 0; k < wpb; k++) model[cur][base+k] = bw[k*32 +: 32];
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) model[cur][idx][b*8 +: 8] = wd[b*8 +: 8];
        end
        exp_blk = '0;
        for (int k = 0; k < wpb; k++) exp_blk[k*32 +: 32] = model[cur][base+k];
        exp_word = model[cur][idx];

        @(negedge clk);
        chk("ready_idle", o_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_block = bk; req_addr = addr;
        req_wdata = wd; req_wstrb = st; req_bw = bw;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!o_rvalid) chk("ready_wait", o_ready, 1'b0);
        end while (!o_rvalid && n < 20);
        chk("latency", n, lat + 1);
        chk("ready_resp", o_ready, 1'b0);
        chk("rdata", o_rdata, exp_word);
        chk("block_rdata", o_block, exp_blk);
        $display("txn dut=%0d write=%0d block=%0d addr=%08h rdata=%08h samples=%0d",
                 cur, w, bk, addr, o_rdata, n);
        @(negedge clk);
        chk("pulse_once", o_rvalid, 1'b0);
    endtask

    function automatic logic [255:0] rnd_blk();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            cur = bit'(d);
            #1;
            chk({tag, "_ready"}, o_ready, 1'b1);
            chk({tag, "_busy"}, o_busy, 1'b0);
            chk({tag, "_rvalid"}, o_rvalid, 1'b0);
            chk({tag, "_rdata"}, o_rdata, 32'h0);
            chk({tag, "_block"}, o_block, 256'h0);
        end
        cur = 1'b0;
    endtask

    initial begin
        int pulses, n, lat;
        logic [31:0] exp1, exp2, addr;
        bit exp_ready;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Default instance: initialise blocks 0..15.
        cur = 1'b0;
        for (int b = 0; b < 16; b++) op(1, 1, 32'(b * 16), 0, 0, rnd_blk());

        op(1, 1, 32'h40, 0, 0, {128'h0, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
        op(0, 0, 32'h48, 0, 0, '0);
        chk("block_word2", a_rdata, 32'h22222222);

        op(1, 0, 32'h44, 32'h11111111, 4'hF, '0);
        op(1, 0, 32'h44, 32'hAABBCCDD, 4'b0101, '0);
        op(0, 0, 32'h44, 0, 0, '0);
        chk("strobe_word", a_rdata, 32'h11BB11DD);

        // Back-to-back requests with req_valid held high.
        lat  = 3;
        exp1 = model[0][4];
        exp2 = model[0][9];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_block = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1 req_addr = 32'h24;
        pulses = 0;
        for (n = 1; n <= 2 * lat + 5; n++) begin
            @(negedge clk);
            exp_ready = (n == lat + 2) || (n > 2 * lat + 3);
            chk("hs_ready", o_ready, exp_ready);
            if (o_rvalid) begin
                pulses++;
                if (pulses == 1) begin
                    chk("hs_lat1", n, lat + 1);
                    chk("hs_data1", o_rdata, exp1);
                end else begin
                    chk("hs_lat2", n, 2 * lat + 3);
                    chk("hs_data2", o_rdata, exp2);
                    req_valid = 1'b0;
                end
                $display("txn dut=0 handshake resp=%0d rdata=%08h sample=%0d", pulses, o_rdata, n);
            end
        end
        req_valid = 1'b0;
        chk("hs_pulses", pulses, 2);

        // clr while a word write waits.
        op(1, 0, 32'h80, 32'h11223344, 4'hF, '0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_block = 1'b0; req_addr = 32'h80;
        req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_ready", a_ready, 1'b1);
        chk("clr_hold_rdata", a_rdata, 32'h11223344);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_rvalid) pulses++;
            @(negedge clk);
        end
        chk("clr_no_resp", pulses, 0);
        $display("txn dut=0 clr-aborted write addr=00000080");
        op(0, 0, 32'h80, 0, 0, '0);

        // Asynchronous reset in the middle of WAIT drops the write.
        op(1, 0, 32'h90, 32'h55667788, 4'hF, '0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_block = 1'b0; req_addr = 32'h90;
        req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("wait_busy", a_busy, 1'b1);
        #2 rst = 1'b0;
        check_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", a_ready, 1'b1);
        $display("txn dut=0 reset-aborted write addr=00000090");
        op(0, 0, 32'h90, 0, 0, '0);

        // Random traffic; upper address bits are randomised to exercise aliasing.
        for (int i = 0; i < 40; i++) begin
            addr = (32'($urandom_range(0, 15)) << 14) | (32'($urandom_range(0, 15)) << 4) |
                   (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, addr,
               $urandom, 4'($urandom_range(0, 15)), rnd_blk());
        end

        // Small instance: 8 words per block, latency 1, 16 blocks.
        cur = 1'b1;
        for (int b = 0; b < 16; b++) op(1, 1, 32'(b * 32), 0, 0, rnd_blk());
        op(1, 1, 32'h200, 0, 0, rnd_blk());
        op(0, 0, 32'h0, 0, 0, '0);
        chk("alias_word0", b_rdata, model[1][0]);
        op(0, 1, 32'h1C, 0, 0, '0);
        for (int i = 0; i < 30; i++) begin
            addr = (32'($urandom_range(0, 7)) << 9) | (32'($urandom_range(0, 15)) << 5) |
                   (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, addr,
               $urandom, 4'($urandom_range(0, 15)), rnd_blk());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
